// File: rtl/core_pkg.sv
// Shared types and constants for the execute-stage pipeline controller.
package core_pkg;
    localparam int XLEN = 64;

    typedef enum logic [2:0] {
        RUN     = 3'd0,
        IO_WAIT = 3'd1,
        SLEEP   = 3'd2,
        DRAIN   = 3'd3,
        HALT    = 3'd4
    } pipe_state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/exe_wait_timer.sv
// Down-counter with load, clear and saturating decrement; expire flags zero.
module exe_wait_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         clear,
    input  logic         dec,
    output logic         expire
);
    logic [W-1:0] count;

    // load takes precedence so a new wait can start in the same cycle another ends
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (clear) begin
            count <= '0;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign expire = (count == '0);
endmodule

// File: rtl/exe_pipe_ctrl.sv
// Execute-stage sequencer: turns EX events into stall/flush/redirect and owns
// WFI sleep, the bus-wait timeout and the test-mode drain-to-halt exit.
module exe_pipe_ctrl #(
    parameter int XLEN       = core_pkg::XLEN,
    parameter int EXIT_DELAY = 2,
    parameter int IO_TIMEOUT = 1023
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            io_req,
    input  logic            io_ack,
    input  logic            bj_en,
    input  logic [XLEN-1:0] bj_pc,
    input  logic            trap_en,
    input  logic [XLEN-1:0] trap_vec,
    input  logic            wfi_op,
    input  logic            irq_pending,
    input  logic            test_mode,
    output logic            stall,
    output logic            flush,
    output logic            redirect_en,
    output logic [XLEN-1:0] redirect_pc,
    output logic            sleeping,
    output logic            halt,
    output logic            io_fault
);
    import core_pkg::*;

    // One counter serves both waits, so it is sized for the longer of the two.
    localparam int CW = max_int($clog2(IO_TIMEOUT + 1), $clog2(EXIT_DELAY + 1));
    localparam logic [CW-1:0] EXIT_LOAD = CW'(EXIT_DELAY - 1);
    localparam logic [CW-1:0] IO_LOAD   = CW'(IO_TIMEOUT);

    pipe_state_e   state;
    pipe_state_e   state_next;
    logic          fault_next;
    logic          tmr_load;
    logic [CW-1:0] tmr_load_val;
    logic          tmr_clear;
    logic          tmr_dec;
    logic          tmr_expire;

    exe_wait_timer #(.W(CW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_load_val),
        .clear    (tmr_clear),
        .dec      (tmr_dec),
        .expire   (tmr_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RUN;
            io_fault <= 1'b0;
        end else begin
            state    <= state_next;
            io_fault <= fault_next;
        end
    end

    always_comb begin
        state_next   = state;
        fault_next   = 1'b0;
        stall        = 1'b0;
        flush        = 1'b0;
        redirect_en  = 1'b0;
        redirect_pc  = '0;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        tmr_dec      = 1'b0;
        case (state)
            RUN: begin
                if (trap_en) begin
                    redirect_en = 1'b1;
                    redirect_pc = trap_vec;
                    flush       = 1'b1;
                end else if (bj_en) begin
                    redirect_en = 1'b1;
                    redirect_pc = bj_pc;
                    flush       = 1'b1;
                end else if (wfi_op) begin
                    if (test_mode) begin
                        stall        = 1'b1;
                        tmr_load     = 1'b1;
                        tmr_load_val = EXIT_LOAD;
                        state_next   = DRAIN;
                    end else if (!irq_pending) begin
                        stall      = 1'b1;
                        state_next = SLEEP;
                    end
                end else if (io_req && !io_ack) begin
                    stall        = 1'b1;
                    tmr_load     = 1'b1;
                    tmr_load_val = IO_LOAD;
                    state_next   = IO_WAIT;
                end
            end
            // Counting down from IO_TIMEOUT reaches zero exactly when the wait count hits the limit.
            IO_WAIT: begin
                if (io_ack) begin
                    state_next = RUN;
                end else if (tmr_expire) begin
                    stall      = 1'b1;
                    fault_next = 1'b1;
                    state_next = RUN;
                end else begin
                    stall   = 1'b1;
                    tmr_dec = 1'b1;
                end
            end
            SLEEP: begin
                stall = 1'b1;
                if (irq_pending) state_next = RUN;
            end
            DRAIN: begin
                stall = 1'b1;
                if (tmr_expire) state_next = HALT;
                else            tmr_dec    = 1'b1;
            end
            HALT: begin
                stall = 1'b1;
            end
            default: begin
                state_next = RUN;
            end
        endcase
        // Quiet the combinational controls while reset is held, whatever EX presents.
        if (rst) begin
            stall       = 1'b0;
            flush       = 1'b0;
            redirect_en = 1'b0;
            redirect_pc = '0;
        end
    end

    assign tmr_clear = (state != RUN) && (state_next == RUN);
    assign sleeping  = (state == SLEEP);
    assign halt      = (state == HALT);
endmodule

// File: tb/tb_exe_pipe_ctrl.sv
// Self-checking bench for exe_pipe_ctrl: directed table, hand-written corner
// sequences and randomized traffic against an event-level reference model.
module tb_exe_pipe_ctrl;
    localparam int XLEN       = 64;
    localparam int EXIT_DELAY = 2;
    localparam int IO_TIMEOUT = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            io_req, io_ack, bj_en, trap_en, wfi_op, irq_pending, test_mode;
    logic [XLEN-1:0] bj_pc, trap_vec;
    logic            stall, flush, redirect_en, sleeping, halt, io_fault;
    logic [XLEN-1:0] redirect_pc;

    always #5 clk = ~clk;

    exe_pipe_ctrl #(.XLEN(XLEN), .EXIT_DELAY(EXIT_DELAY), .IO_TIMEOUT(IO_TIMEOUT)) dut (
        .clk(clk), .rst(rst), .io_req(io_req), .io_ack(io_ack), .bj_en(bj_en),
        .bj_pc(bj_pc), .trap_en(trap_en), .trap_vec(trap_vec), .wfi_op(wfi_op),
        .irq_pending(irq_pending), .test_mode(test_mode), .stall(stall), .flush(flush),
        .redirect_en(redirect_en), .redirect_pc(redirect_pc), .sleeping(sleeping),
        .halt(halt), .io_fault(io_fault)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: what the core is doing, not how the controller encodes it.
    bit              m_bus_wait, m_asleep, m_halted, m_fault;
    int              m_bus_cycles, m_drain_left;
    bit              nx_bus_wait, nx_asleep, nx_halted, nx_fault;
    int              nx_bus_cycles, nx_drain_left;
    bit              e_stall, e_flush, e_redir;
    logic [XLEN-1:0] e_pc;

    typedef struct {
        bit              trap;
        bit              bj;
        logic [XLEN-1:0] bpc;
        logic [XLEN-1:0] tvec;
        bit              wfi;
        bit              irq;
        bit              req;
        bit              ack;
        bit              x_stall;
        bit              x_flush;
        bit              x_redir;
        logic [XLEN-1:0] x_pc;
    } vec_t;

    vec_t vecs[8];

    task automatic checkVal(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        m_bus_wait   = 0;
        m_asleep     = 0;
        m_halted     = 0;
        m_fault      = 0;
        m_bus_cycles = 0;
        m_drain_left = 0;
    endtask

    task automatic modelEval();
        e_stall       = 0;
        e_flush       = 0;
        e_redir       = 0;
        e_pc          = '0;
        nx_bus_wait   = m_bus_wait;
        nx_asleep     = m_asleep;
        nx_halted     = m_halted;
        nx_bus_cycles = m_bus_cycles;
        nx_drain_left = m_drain_left;
        nx_fault      = 0;
        if (m_halted) begin
            e_stall = 1;
        end else if (m_drain_left > 0) begin
            e_stall       = 1;
            nx_drain_left = m_drain_left - 1;
            if (nx_drain_left == 0) nx_halted = 1;
        end else if (m_bus_wait) begin
            if (io_ack) begin
                nx_bus_wait = 0;
            end else begin
                e_stall = 1;
                if (m_bus_cycles == IO_TIMEOUT) begin
                    nx_fault    = 1;
                    nx_bus_wait = 0;
                end else begin
                    nx_bus_cycles = m_bus_cycles + 1;
                end
            end
        end else if (m_asleep) begin
            e_stall = 1;
            if (irq_pending) nx_asleep = 0;
        end else if (trap_en) begin
            e_redir = 1; e_flush = 1; e_pc = trap_vec;
        end else if (bj_en) begin
            e_redir = 1; e_flush = 1; e_pc = bj_pc;
        end else if (wfi_op) begin
            if (test_mode) begin
                e_stall       = 1;
                nx_drain_left = EXIT_DELAY;
            end else if (!irq_pending) begin
                e_stall   = 1;
                nx_asleep = 1;
            end
        end else if (io_req && !io_ack) begin
            e_stall       = 1;
            nx_bus_wait   = 1;
            nx_bus_cycles = 0;
        end
    endtask

    task automatic modelCommit();
        m_bus_wait   = nx_bus_wait;
        m_asleep     = nx_asleep;
        m_halted     = nx_halted;
        m_fault      = nx_fault;
        m_bus_cycles = nx_bus_cycles;
        m_drain_left = nx_drain_left;
    endtask

    task automatic checkOutput(input string name);
        checkVal({name, ".stall"},       XLEN'(stall),       XLEN'(e_stall));
        checkVal({name, ".flush"},       XLEN'(flush),       XLEN'(e_flush));
        checkVal({name, ".redirect_en"}, XLEN'(redirect_en), XLEN'(e_redir));
        checkVal({name, ".redirect_pc"}, redirect_pc,        e_pc);
        checkVal({name, ".sleeping"},    XLEN'(sleeping),    XLEN'(m_asleep));
        checkVal({name, ".halt"},        XLEN'(halt),        XLEN'(m_halted));
        checkVal({name, ".io_fault"},    XLEN'(io_fault),    XLEN'(m_fault));
    endtask

    task automatic applyStimulus(input bit t, input bit b, input logic [XLEN-1:0] bpc,
                                 input logic [XLEN-1:0] tvec, input bit w, input bit irq,
                                 input bit req, input bit ack);
        trap_en = t; bj_en = b; bj_pc = bpc; trap_vec = tvec;
        wfi_op = w; irq_pending = irq; io_req = req; io_ack = ack;
    endtask

    task automatic randomInputs();
        applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                      {$urandom, $urandom}, {$urandom, $urandom},
                      $urandom_range(0, 15) == 0, $urandom_range(0, 3) == 0,
                      $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0);
    endtask

    task automatic sampleCycle(input string name);
        @(negedge clk);
        modelEval();
        checkOutput(name);
    endtask

    task automatic advance();
        @(posedge clk);
        modelCommit();
        #2;
    endtask

    // Reset lands between clock edges; the outputs must clear before any edge.
    task automatic asyncReset(input string name);
        @(negedge clk);
        #2;
        applyStimulus(1, 1, 64'h1111, 64'h2222, 1, 0, 1, 0);
        rst = 1'b1;
        #1;
        checkVal({name, ".stall"},       XLEN'(stall),       '0);
        checkVal({name, ".flush"},       XLEN'(flush),       '0);
        checkVal({name, ".redirect_en"}, XLEN'(redirect_en), '0);
        checkVal({name, ".redirect_pc"}, redirect_pc,        '0);
        checkVal({name, ".sleeping"},    XLEN'(sleeping),    '0);
        checkVal({name, ".halt"},        XLEN'(halt),        '0);
        checkVal({name, ".io_fault"},    XLEN'(io_fault),    '0);
        modelReset();
        applyStimulus(0, 0, '0, '0, 0, 0, 0, 0);
        @(posedge clk);
        #3;
        rst = 1'b0;
    endtask

    initial begin
        vecs[0] = '{0, 1, 64'h8000_0100, 64'h0000_1234, 0, 0, 0, 0, 0, 1, 1, 64'h8000_0100};
        vecs[1] = '{0, 0, 64'h8000_0100, 64'h0000_1234, 0, 0, 0, 0, 0, 0, 0, 64'h0};
        vecs[2] = '{1, 1, 64'h8000_0100, 64'h8000_0000, 0, 0, 0, 0, 0, 1, 1, 64'h8000_0000};
        vecs[3] = '{1, 0, 64'h0,         64'h8000_0040, 0, 0, 1, 0, 0, 1, 1, 64'h8000_0040};
        vecs[4] = '{0, 0, 64'h0,         64'h0,         0, 0, 1, 1, 0, 0, 0, 64'h0};
        vecs[5] = '{0, 0, 64'h0,         64'h0,         1, 1, 0, 0, 0, 0, 0, 64'h0};
        vecs[6] = '{0, 1, 64'hDEAD_BEEF, 64'h0,         1, 0, 0, 0, 0, 1, 1, 64'hDEAD_BEEF};
        vecs[7] = '{1, 0, 64'h0,         64'hFFFF_FFFF_FFFF_FFF0, 1, 0, 1, 0, 0, 1, 1, 64'hFFFF_FFFF_FFFF_FFF0};

        test_mode = 1'b0;
        rst       = 1'b1;
        applyStimulus(1, 1, 64'h55, 64'h66, 0, 0, 1, 0);
        modelReset();
        #12;
        checkVal("reset.stall",       XLEN'(stall),       '0);
        checkVal("reset.flush",       XLEN'(flush),       '0);
        checkVal("reset.redirect_en", XLEN'(redirect_en), '0);
        checkVal("reset.redirect_pc", redirect_pc,        '0);
        checkVal("reset.halt",        XLEN'(halt),        '0);
        applyStimulus(0, 0, '0, '0, 0, 0, 0, 0);
        rst = 1'b0;
        @(posedge clk);
        #2;

        // Single-cycle RUN decoding, each vector leaves the core in RUN.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].trap, vecs[i].bj, vecs[i].bpc, vecs[i].tvec,
                          vecs[i].wfi, vecs[i].irq, vecs[i].req, vecs[i].ack);
            sampleCycle($sformatf("vec%0d", i));
            checkVal($sformatf("vec%0d.tbl_stall", i), XLEN'(stall),       XLEN'(vecs[i].x_stall));
            checkVal($sformatf("vec%0d.tbl_flush", i), XLEN'(flush),       XLEN'(vecs[i].x_flush));
            checkVal($sformatf("vec%0d.tbl_redir", i), XLEN'(redirect_en), XLEN'(vecs[i].x_redir));
            checkVal($sformatf("vec%0d.tbl_pc", i),    redirect_pc,        vecs[i].x_pc);
            advance();
        end

        // Bus access acknowledged on the fourth cycle.
        for (int c = 0; c < 4; c++) begin
            applyStimulus(0, 0, '0, '0, 0, 0, 1, c == 3);
            sampleCycle("io_ack");
            checkVal($sformatf("io_ack.c%0d_stall", c), XLEN'(stall), XLEN'(c != 3));
            checkVal($sformatf("io_ack.c%0d_fault", c), XLEN'(io_fault), '0);
            advance();
        end
        applyStimulus(0, 0, '0, '0, 0, 0, 0, 0);
        sampleCycle("io_ack_after");
        checkVal("io_ack_after.fault", XLEN'(io_fault), '0);
        advance();

        // Bus never answers: RUN cycle plus IO_TIMEOUT+1 wait cycles, then a fault pulse.
        for (int c = 0; c < IO_TIMEOUT + 2; c++) begin
            applyStimulus(0, 0, '0, '0, 0, 0, 1, 0);
            sampleCycle("io_to");
            checkVal($sformatf("io_to.c%0d_stall", c), XLEN'(stall), 1);
            checkVal($sformatf("io_to.c%0d_fault", c), XLEN'(io_fault), '0);
            advance();
        end
        applyStimulus(0, 0, '0, '0, 0, 0, 0, 0);
        sampleCycle("io_to_fault");
        checkVal("io_to_fault.pulse", XLEN'(io_fault), 1);
        checkVal("io_to_fault.stall", XLEN'(stall), '0);
        advance();
        sampleCycle("io_to_after");
        checkVal("io_to_after.pulse", XLEN'(io_fault), '0);
        advance();

        // WFI sleep, woken by an interrupt at cycle 10.
        for (int c = 0; c < 12; c++) begin
            applyStimulus(0, 0, '0, '0, c == 0, c >= 10, 0, 0);
            sampleCycle("sleep");
            checkVal($sformatf("sleep.c%0d_sleeping", c), XLEN'(sleeping), XLEN'(c >= 1 && c <= 10));
            checkVal($sformatf("sleep.c%0d_stall", c),    XLEN'(stall),    XLEN'(c <= 10));
            advance();
        end

        // Randomized traffic against the model, with occasional asynchronous resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) asyncReset("rand_rst");
            randomInputs();
            sampleCycle("rand");
            advance();
        end

        // Reset while parked in the bus wait, then normal RUN behaviour resumes.
        applyStimulus(0, 0, '0, '0, 0, 0, 0, 0);
        sampleCycle("pre_iow");
        advance();
        applyStimulus(0, 0, '0, '0, 0, 0, 1, 0);
        sampleCycle("iow_enter");
        advance();
        sampleCycle("iow_mid");
        checkVal("iow_mid.stall", XLEN'(stall), 1);
        advance();
        asyncReset("rst_iow");
        applyStimulus(0, 1, 64'h8000_0100, '0, 0, 0, 0, 0);
        sampleCycle("post_iow");
        checkVal("post_iow.redirect_pc", redirect_pc, 64'h8000_0100);
        advance();

        // Test-mode exit: WFI, two drain cycles, then sticky halt.
        applyStimulus(0, 0, '0, '0, 0, 0, 0, 0);
        test_mode = 1'b1;
        sampleCycle("tm_idle");
        advance();
        for (int c = 0; c < 4; c++) begin
            applyStimulus(0, 0, '0, '0, c == 0, 0, 0, 0);
            sampleCycle("drain");
            checkVal($sformatf("drain.c%0d_stall", c), XLEN'(stall), 1);
            checkVal($sformatf("drain.c%0d_halt", c),  XLEN'(halt),  XLEN'(c == 3));
            advance();
        end
        for (int i = 0; i < 20; i++) begin
            randomInputs();
            sampleCycle("halted");
            checkVal("halted.halt", XLEN'(halt), 1);
            checkVal("halted.redirect_en", XLEN'(redirect_en), '0);
            advance();
        end
        asyncReset("rst_halt");

        // Reset in the middle of the drain.
        applyStimulus(0, 0, '0, '0, 1, 0, 0, 0);
        sampleCycle("drain2_enter");
        advance();
        applyStimulus(0, 0, '0, '0, 0, 0, 0, 0);
        sampleCycle("drain2_mid");
        advance();
        asyncReset("rst_drain");
        test_mode = 1'b0;
        applyStimulus(1, 0, '0, 64'h8000_0000, 0, 0, 0, 0);
        sampleCycle("post_drain");
        checkVal("post_drain.halt", XLEN'(halt), '0);
        advance();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 0, '0, '0, 0, 0, 0, 0);
            sampleCycle("post_drain_idle");
            advance();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
